// File: rtl/blue_status_tx.sv
// rtl/blue_status_tx.sv - 8N1 UART transmitter sending "V<v>S<s>\r\n" status frames
// A frame goes out on any volume/song change, on send_req, and once after reset.
module blue_status_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] volume,
  input  logic [3:0] song,
  input  logic       send_req,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [2:0]    byte_idx, byte_n;
  logic          tx_n, busy_n, done_n;
  logic [1:0]    vol_s, vol_n;
  logic [3:0]    song_s, song_n;
  logic          pend_req, pend_n;

  logic [7:0] cur_byte;
  logic [2:0] bit_nxt;
  logic       trig;
  logic       baud_end;

  // Frame content comes only from the snapshot, never from the live inputs.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:    cur_byte = 8'h56;
      3'd1:    cur_byte = 8'h30 + {6'd0, vol_s};
      3'd2:    cur_byte = 8'h53;
      3'd3:    cur_byte = (song_s <= 4'd9) ? (8'h30 + {4'd0, song_s}) : 8'h3F;
      3'd4:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign bit_nxt  = bit_idx + 3'd1;
  assign trig     = pend_req | send_req | (volume != vol_s) | (song != song_s);
  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 3'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      vol_s      <= 2'd3;
      song_s     <= 4'd1;
      pend_req   <= 1'b1;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      byte_idx   <= byte_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
      vol_s      <= vol_n;
      song_s     <= song_n;
      pend_req   <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    vol_n   = vol_s;
    song_n  = song_s;
    // Requests arriving mid-frame collapse into one follow-up frame.
    pend_n  = pend_req | send_req;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (trig) begin
          vol_n   = volume;
          song_n  = song;
          pend_n  = 1'b0;
          byte_n  = 3'd0;
          baud_n  = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          tx_n    = cur_byte[0];
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n = bit_nxt;
            tx_n  = cur_byte[bit_nxt];
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          // Next start bit follows the stop bit with no idle gap.
          if (byte_idx < 3'd5) begin
            byte_n  = byte_idx + 3'd1;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blue_status_tx.sv
// tb/tb_blue_status_tx.sv - randomized bench for blue_status_tx against a frame-level model
// The model predicts the tx waveform from frame start times and the byte layout.
module tb_blue_status_tx;

  localparam int CPB   = 4;
  localparam int FLEN  = 60 * CPB;
  localparam int BLEN  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] volume;
  logic [3:0] song;
  logic       send_req;
  logic       tx, busy, frame_done;

  int n_checks = 0;
  int n_errors = 0;

  blue_status_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .volume(volume), .song(song), .send_req(send_req),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state after each rising edge.
  int         cyc = 0;
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  int         m_p = 0;
  logic [1:0] m_vol = 2'd3;
  logic [3:0] m_song = 4'd1;
  bit         m_pend = 1'b1;
  logic [7:0] m_frame [6];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_p = 0;
      m_vol = 2'd3; m_song = 4'd1; m_pend = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (send_req) m_pend = 1'b1;
        m_p++;
        if (m_p == FLEN) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end else if (m_pend || send_req || volume != m_vol || song != m_song) begin
        m_vol = volume; m_song = song; m_pend = 1'b0;
        m_frame[0] = 8'h56;
        m_frame[1] = 8'h30 + 8'(m_vol);
        m_frame[2] = 8'h53;
        m_frame[3] = (m_song < 10) ? 8'h30 + 8'(m_song) : 8'h3F;
        m_frame[4] = 8'h0D;
        m_frame[5] = 8'h0A;
        m_active = 1'b1;
        m_p = 0;
      end
    end
  end

  function automatic logic exp_line();
    int b, k;
    if (rst || !m_active) return 1'b1;
    b = m_p / BLEN;
    k = (m_p % BLEN) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_frame[b][k-1];
  endfunction

  // Waveform comparison and frame bookkeeping, away from the active edge.
  int   fd_count = 0;
  int   starts[$];
  int   dones[$];
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    check("tx_wave", 32'(tx), 32'(exp_line()));
    check("busy_wave", 32'(busy), 32'((!rst) && m_active));
    check("done_wave", 32'(frame_done), 32'((!rst) && m_done));
    if (frame_done) begin
      fd_count++;
      dones.push_back(cyc);
    end
    if (busy && !busy_q) starts.push_back(cyc);
    busy_q = busy;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    wait_cyc(1);
    send_req = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1; volume = 2'd3; song = 4'd1; send_req = 1'b0;
    wait_cyc(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    #1 rst = 1'b0;

    // One frame after reset, 240 cycles long, then silence.
    wait_cyc(400);
    check("boot_frames", 32'(fd_count), 32'd1);
    if (starts.size() > 0 && dones.size() > 0)
      check("boot_len", 32'(dones[0] - starts[0]), 32'(FLEN));
    else
      check("boot_seen", 32'(dones.size()), 32'd1);
    check("boot_idle_tx", 32'(tx), 32'd1);

    // Volume change starts a frame on the sampling edge.
    base = fd_count;
    volume = 2'd2;
    wait_cyc(1);
    check("vol_tx_fall", 32'(tx), 32'd0);
    wait_cyc(300);
    check("vol_frames", 32'(fd_count - base), 32'd1);

    // Song >= 10 yields '?', then a bare request re-sends it.
    base = fd_count;
    song = 4'd12;
    wait_cyc(300);
    pulse_req();
    wait_cyc(300);
    check("song12_frames", 32'(fd_count - base), 32'd2);

    // Mid-frame change plus two requests -> exactly one follow-up frame.
    song = 4'd1;
    wait_cyc(300);
    base = fd_count;
    pulse_req();
    wait_cyc(48);
    song = 4'd5;
    pulse_req();
    wait_cyc(10);
    pulse_req();
    wait_cyc(700);
    check("followup_frames", 32'(fd_count - base), 32'd2);
    if (starts.size() >= 2 && dones.size() >= 2)
      check("followup_gap", 32'(starts[starts.size()-1] - dones[dones.size()-2]), 32'd1);

    // Change and revert within a frame -> no second frame.
    volume = 2'd3;
    wait_cyc(300);
    base = fd_count;
    pulse_req();
    wait_cyc(40);
    volume = 2'd1;
    wait_cyc(60);
    volume = 2'd3;
    wait_cyc(500);
    check("revert_frames", 32'(fd_count - base), 32'd1);
    check("revert_idle_tx", 32'(tx), 32'd1);

    // Reset mid-byte: line returns high at once, then one fresh frame.
    base = fd_count;
    pulse_req();
    song = 4'($urandom_range(0, 15));
    volume = 2'($urandom_range(0, 3));
    wait_cyc(68);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    wait_cyc(3);
    #1 rst = 1'b0;
    wait_cyc(400);
    check("post_rst_frames", 32'(fd_count - base), 32'd1);
    if (starts.size() > 0 && dones.size() > 0)
      check("post_rst_len", 32'(dones[dones.size()-1] - starts[starts.size()-1]), 32'(FLEN));

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: volume = 2'($urandom_range(0, 3));
        1: song = 4'($urandom_range(0, 15));
        2: pulse_req();
        default: begin
          song = 4'($urandom_range(0, 15));
          pulse_req();
        end
      endcase
      wait_cyc($urandom_range(1, 300));
    end
    wait_cyc(800);
    check("final_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/blue_status_tx.md
Name: blue_status_tx

Overview:
- UART transmitter that reports player status to the Bluetooth module. It is the return path of the Bluetooth command receiver, which decodes ASCII '1'..'4' into volume and song updates.
- Watches the volume and song registers and sends a 6-byte ASCII status frame "V<v>S<s>\r\n" whenever either value changes, when explicitly requested, and once after reset.
- Sits between the volume/song control logic and the Bluetooth module RX pin.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); must be >= 2.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-high reset.
- volume  input  2  current volume level, 0..3.
- song  input  4  current song index.
- send_req  input  1  single-cycle pulse; forces one status frame.
- tx  output  1  UART line to the Bluetooth module; idle high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  single-cycle pulse after the last stop bit of a frame.

Behaviour:
- Reset (async, rst=1): tx=1, busy=0, frame_done=0, state=IDLE, bit/byte/baud counters=0, snapshot regs vol_s=3 and song_s=1, pend_req=1. The pending request guarantees exactly one status frame after reset is released.
- UART format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1, each held exactly CLKS_PER_BIT cycles. tx is a registered output.
- Frame bytes, in order:
  - 0x56 'V'
  - 0x30+vol_s
  - 0x53 'S'
  - song character: 0x30+song_s when song_s<=9, 0x3F '?' when song_s>=10
  - 0x0D
  - 0x0A
- No idle gap between bytes: the stop bit of byte k is followed directly by the start bit of byte k+1.
- Trigger, evaluated in IDLE only: trig = pend_req | send_req | (volume!=vol_s) | (song!=song_s).
- States:
  - IDLE: tx=1, busy=0. On the edge where trig=1: latch vol_s<=volume and song_s<=song, clear pend_req, byte_idx=0, drive tx<=0, busy<=1, go to START. tx therefore falls on the same edge that samples the trigger.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: output bit bit_idx of the current byte for CLKS_PER_BIT cycles each. After bit 7, go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<5: increment byte_idx and go to START.
    - else: pulse frame_done for 1 cycle, set busy<=0, go to IDLE.
- Frame length: 60*CLKS_PER_BIT cycles from the tx falling edge to frame_done.
- Snapshot rule: frame contents come only from vol_s/song_s, which are latched at frame start. Input changes mid-frame never corrupt the frame in flight.
- send_req while busy: sets pend_req, which is cleared when the next frame starts. Multiple requests during one frame collapse into one follow-up frame.
- Value changes while busy: no flag is needed. On return to IDLE the comparison against the snapshot retriggers. The first IDLE cycle sees the trigger, so consecutive frames are separated by exactly 1 idle-high cycle.
- If a value changes and then returns to its snapshot value within one frame, no follow-up frame is sent, unless pend_req is set.
- send_req together with a value change in IDLE: a single frame is sent, carrying the new values.
- rst asserted mid-frame: tx returns high immediately. The partial byte is abandoned, not completed. After release, one fresh frame is sent because pend_req=1.

Test Plan:
- CLKS_PER_BIT=4; release reset with volume=3, song=1, send_req never asserted -> tx shows bytes 0x56,0x33,0x53,0x31,0x0D,0x0A. frame_done pulses 240 cycles after tx falls; busy then goes 0 and tx stays 1 with no further frame.
- Idle, then volume 3->2 -> tx falls on the same edge; bytes 0x56,0x32,0x53,0x31,0x0D,0x0A.
- Idle, song=12 via send_req with no value change -> fourth byte 0x3F.
- During a frame, change song 1->5 at cycle 50 and pulse send_req twice -> the in-flight frame still carries '1'. Exactly one follow-up frame carries '5', with tx falling 1 cycle after frame_done.
- During a frame, change volume 3->1 and back to 3 before frame_done -> no second frame; tx stays 1.
- Assert rst at cycle 70 mid-byte -> tx=1 and busy=0 immediately, asynchronously. After release, one complete frame is sent with the current values.
